muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide unit with its HI/LO register pair, sequenced for the 5-stage MIPS pipeline. The E-stage issues MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO operations using the control unit's `MulOp`, `MTHILO` and `MFHILO` encodings. The block models fixed operation latencies with a down-counter and exposes `busy` so the hazard unit can stall dependent HI/LO instructions. It owns HI and LO; no other block writes them.

---
 rtl/muldiv_sequencer.sv | 139 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO. Results are computed at issue,
// held in result registers, and committed to HI/LO after a fixed busy latency.
module muldiv_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mul_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mt_en,
  input  logic        mt_sel,
  input  logic [1:0]  mf_sel,
  output logic        busy,
  output logic [31:0] hilo_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned DW         = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    res_hi_q, res_hi_d;
  logic [DW-1:0]    res_lo_q, res_lo_d;
  logic             res_dz_q, res_dz_d;
  logic [DW-1:0]    hi_q, hi_d;
  logic [DW-1:0]    lo_q, lo_d;

  // Operation datapath, evaluated on the issuing cycle's operands
  logic [2*DW-1:0] prod_u, prod_s;
  logic            is_signed, a_neg, b_neg, div_zero;
  logic [DW-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    prod_u    = {{DW{1'b0}}, src_a} * {{DW{1'b0}}, src_b};
    // low 64 bits of the product of sign-extended operands equal the signed product
    prod_s    = {{DW{src_a[DW-1]}}, src_a} * {{DW{src_b[DW-1]}}, src_b};
    is_signed = mul_op[0];
    a_neg     = is_signed & src_a[DW-1];
    b_neg     = is_signed & src_b[DW-1];
    a_mag     = a_neg ? DW'(-src_a) : src_a;
    b_mag     = b_neg ? DW'(-src_b) : src_b;
    div_zero  = (src_b == '0);
    b_safe    = div_zero ? DW'(1) : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    quot      = (a_neg ^ b_neg) ? DW'(-q_mag) : q_mag;
    rem       = a_neg ? DW'(-r_mag) : r_mag;
  end

  // Next-state, counter, result latch and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_dz_d = res_dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          if (mul_op[1]) begin
            cnt_d    = CNT_W'(DIV_CYCLES);
            res_hi_d = rem;
            res_lo_d = quot;
            res_dz_d = div_zero;
          end else begin
            cnt_d    = CNT_W'(MULT_CYCLES);
            res_hi_d = is_signed ? prod_s[2*DW-1:DW] : prod_u[2*DW-1:DW];
            res_lo_d = is_signed ? prod_s[DW-1:0]    : prod_u[DW-1:0];
            res_dz_d = 1'b0;
          end
        end else if (mt_en) begin
          if (mt_sel) hi_d = src_a;
          else        lo_d = src_a;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          // divide by zero leaves HI/LO untouched
          if (!res_dz_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_dz_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_dz_q <= res_dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // MFHI/MFLO read mux
  always_comb begin
    hilo_out = '0;
    unique case (mf_sel)
      2'b01:   hilo_out = lo_q;
      2'b10:   hilo_out = hi_q;
      default: hilo_out = '0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: issued ops push expected HI/LO and latency,
// a monitor checks them when busy falls; direct checks cover MT/MF and reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mul_op;
  logic [31:0] src_a, src_b;
  logic        mt_en, mt_sel;
  logic [1:0]  mf_sel;
  logic        busy;
  logic [31:0] hilo_out, hi, lo;

  muldiv_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mul_op(mul_op),
    .src_a(src_a), .src_b(src_b), .mt_en(mt_en), .mt_sel(mt_sel),
    .mf_sel(mf_sel), .busy(busy), .hilo_out(hilo_out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          ncyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor: samples 1ns after each rising edge
  logic        prev_busy = 1'b0;
  bit          in_op     = 1'b0;
  int          cyc       = 0;
  logic [31:0] pre_hi, pre_lo;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset === 1'b1) begin
      if (in_op && exp_q.size() > 0) void'(exp_q.pop_front());
      in_op = 1'b0;
    end else if (!prev_busy && busy === 1'b1) begin
      in_op  = 1'b1;
      cyc    = 1;
      pre_hi = hi;
      pre_lo = lo;
    end else if (prev_busy && busy === 1'b1) begin
      cyc++;
      chk("hold_hi", hi, pre_hi);
      chk("hold_lo", lo, pre_lo);
    end else if (prev_busy && busy !== 1'b1) begin
      in_op = 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_commit", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.ncyc));
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
      end
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.name = name; e.hi = eh; e.lo = el; e.ncyc = op[1] ? 10 : 5;
    @(negedge clk);
    start = 1'b1; mul_op = op; src_a = a; src_b = b;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && busy === 1'b1; i++) @(negedge clk);
    if (busy === 1'b1) chk({name, "_timeout"}, 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    issue(name, op, a, b, eh, el);
    wait_idle(name);
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] v);
    @(negedge clk);
    mt_en = 1'b1; mt_sel = sel; src_a = v;
    @(negedge clk);
    mt_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mul_op = 2'b00; src_a = '0; src_b = '0;
    mt_en = 1'b0; mt_sel = 1'b0; mf_sel = 2'b01;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hilo_out", hilo_out, 32'h0);

    // MT/MF paths
    mt_write(1'b0, 32'h0000_1234);
    chk("mtlo_lo", lo, 32'h0000_1234);
    mf_sel = 2'b01; #1 chk("mflo", hilo_out, 32'h0000_1234);
    mt_write(1'b1, 32'h0000_5678);
    chk("mthi_hi", hi, 32'h0000_5678);
    mf_sel = 2'b10; #1 chk("mfhi", hilo_out, 32'h0000_5678);
    mf_sel = 2'b00; #1 chk("mf00", hilo_out, 32'h0);
    mf_sel = 2'b11; #1 chk("mf11", hilo_out, 32'h0);
    mf_sel = 2'b01;

    // Arithmetic
    run_op("mult_m2x3",  2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_m2x3", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div_m7d2",   2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7d2",   2'b10, 32'd7,         32'd2, 32'd1,         32'd3);

    // Divide corners
    mt_write(1'b1, 32'h0000_00AA);
    mt_write(1'b0, 32'h0000_00BB);
    run_op("divu_by0", 2'b10, 32'd12345, 32'd0, 32'h0000_00AA, 32'h0000_00BB);
    run_op("div_ovf",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Requests during BUSY are ignored
    issue("mult_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
    @(negedge clk);
    start = 1'b1; mt_en = 1'b1; mt_sel = 1'b0; mul_op = 2'b11; src_a = 32'hDEAD_BEEF; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0; mt_en = 1'b0;
    wait_idle("mult_6x7");

    // start + mt_en together in IDLE: only the multiply
    @(negedge clk);
    start = 1'b1; mt_en = 1'b1; mt_sel = 1'b0; mul_op = 2'b00; src_a = 32'd3; src_b = 32'd4;
    exp_q.push_back('{name: "multu_3x4", hi: 32'd0, lo: 32'd12, ncyc: 5});
    @(negedge clk);
    start = 1'b0; mt_en = 1'b0;
    chk("start_wins_lo", lo, 32'd42);
    wait_idle("multu_3x4");

    // Reset in the third busy cycle of a DIV
    mt_write(1'b1, 32'h0000_0077);
    issue("div_rst", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_hilo_out", hilo_out, 32'h0);
    repeat (15) @(negedge clk);
    chk("no_commit_hi", hi, 32'h0);
    chk("no_commit_lo", lo, 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
